// File: rtl/slow_ctl.sv
// slow_ctl: stretches the slow-speed request across selected bus cycles
// and holds it for a programmable number of timebase ticks afterwards.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no slow request pending
// CYC   | slow bus cycle in progress, waiting for BACT to drop
// HOLD  | post-cycle hold, SlowCount counts down on TimerTick
module slow_ctl (
  input  logic       CLK,
  input  logic       POR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       TimerTick,
  output logic       Slow,
  output logic       ClockGate,
  output logic [3:0] SlowCount
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CYC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] count_nxt;
  logic       bactr;
  logic       bus_sync;
  logic       sel_hit;
  logic       start;
  logic       hit;

  // A cycle that began before reset released must not look like a fresh
  // start, so starts are blocked until BACT has been seen low once.
  assign sel_hit = (IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                   (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd);
  assign start   = BACT & ~bactr & bus_sync;
  assign hit     = start & sel_hit;

  // Bus-cycle edge detection.
  always_ff @(posedge CLK or posedge POR) begin
    if (POR) begin
      bactr    <= 1'b0;
      bus_sync <= 1'b0;
    end else begin
      bactr    <= BACT;
      bus_sync <= bus_sync | ~BACT;
    end
  end

  // Next-state and hold-counter update.
  always_comb begin
    state_nxt = state;
    count_nxt = SlowCount;
    case (state)
      IDLE: begin
        if (hit) state_nxt = CYC;
      end
      CYC: begin
        if (!BACT) begin
          count_nxt = SlowTimeout;
          state_nxt = (SlowTimeout != 4'd0) ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (hit) begin
          state_nxt = CYC;
        end else if (TimerTick) begin
          // <= 1 also covers a zero count so the counter can never wrap.
          if (SlowCount <= 4'd1) begin
            count_nxt = 4'd0;
            state_nxt = IDLE;
          end else begin
            count_nxt = SlowCount - 4'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 4'd0;
      end
    endcase
  end

  // State, counter and outputs, all registered from next-state.
  always_ff @(posedge CLK or posedge POR) begin
    if (POR) begin
      state     <= IDLE;
      SlowCount <= 4'd0;
      Slow      <= 1'b0;
      ClockGate <= 1'b0;
    end else begin
      state     <= state_nxt;
      SlowCount <= count_nxt;
      Slow      <= (state_nxt != IDLE);
      ClockGate <= (state_nxt != IDLE) & SlowClockGate;
    end
  end

endmodule

// File: tb/tb_slow_ctl.sv
// Table-driven bench for slow_ctl; one row per clock, expected values
// computed by hand. Select/enable bit order: {IACK,VIA,IWM,SCC,SCSI,Snd}.
module tb_slow_ctl;

  logic       CLK = 1'b0;
  logic       POR = 1'b0;
  logic       BACT = 1'b0;
  logic [5:0] sel = '0;
  logic [5:0] en = '0;
  logic       SlowClockGate = 1'b0;
  logic [3:0] SlowTimeout = '0;
  logic       TimerTick = 1'b0;
  logic       Slow;
  logic       ClockGate;
  logic [3:0] SlowCount;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] VIA = 6'b010000;
  localparam logic [5:0] IWM = 6'b001000;
  localparam logic [5:0] SCC = 6'b000100;
  localparam logic [5:0] SND = 6'b000001;
  localparam logic [5:0] NON = 6'b000000;

  typedef struct {
    logic       bact;
    logic [5:0] sel;
    logic [5:0] en;
    logic       cg;
    logic [3:0] to;
    logic       tick;
    logic       e_slow;
    logic       e_cg;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  slow_ctl dut (
    .CLK(CLK), .POR(POR), .BACT(BACT),
    .IACKCS(sel[5]), .VIACS(sel[4]), .IWMCS(sel[3]),
    .SCCCS(sel[2]), .SCSICS(sel[1]), .SndCS(sel[0]),
    .SlowIACK(en[5]), .SlowVIA(en[4]), .SlowIWM(en[3]),
    .SlowSCC(en[2]), .SlowSCSI(en[1]), .SlowSnd(en[0]),
    .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout),
    .TimerTick(TimerTick),
    .Slow(Slow), .ClockGate(ClockGate), .SlowCount(SlowCount)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t v(logic b, logic [5:0] s, logic [5:0] e, logic c,
                             logic [3:0] t, logic k, logic es, logic ec,
                             logic [3:0] en_cnt);
    vec_t r;
    r.bact = b; r.sel = s; r.en = e; r.cg = c; r.to = t; r.tick = k;
    r.e_slow = es; r.e_cg = ec; r.e_cnt = en_cnt;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(int idx, logic es, logic ec, logic [3:0] ecnt);
    chk("Slow", idx, {3'b0, Slow}, {3'b0, es});
    chk("ClockGate", idx, {3'b0, ClockGate}, {3'b0, ec});
    chk("SlowCount", idx, SlowCount, ecnt);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //             bact sel  en   cg to  tk  slow cg cnt
    tbl.push_back(v(0, NON, NON, 0, 0, 0,  0, 0, 0));  // 0 sync after reset
    tbl.push_back(v(1, VIA, NON, 0, 3, 0,  0, 0, 0));  // 1 VIA not enabled
    tbl.push_back(v(1, VIA, NON, 0, 3, 0,  0, 0, 0));
    tbl.push_back(v(0, NON, NON, 0, 3, 0,  0, 0, 0));
    tbl.push_back(v(1, SCC, VIA, 0, 3, 0,  0, 0, 0));  // 4 SCC disabled
    tbl.push_back(v(0, NON, VIA, 0, 3, 0,  0, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 3, 0,  1, 0, 0));  // 6 VIA hit, 6 clk
    tbl.push_back(v(1, VIA, VIA, 0, 3, 0,  1, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 3, 0,  1, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 3, 0,  1, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 3, 0,  1, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 3, 0,  1, 0, 0));
    tbl.push_back(v(0, NON, VIA, 0, 3, 0,  1, 0, 3));  // 12 CYC exit load 3
    tbl.push_back(v(0, NON, VIA, 0, 3, 0,  1, 0, 3));
    tbl.push_back(v(0, NON, VIA, 0, 3, 1,  1, 0, 2));
    tbl.push_back(v(0, NON, VIA, 0, 7, 0,  1, 0, 2));  // 15 timeout change ignored
    tbl.push_back(v(0, NON, VIA, 0, 7, 0,  1, 0, 2));
    tbl.push_back(v(0, NON, VIA, 0, 7, 1,  1, 0, 1));
    tbl.push_back(v(0, NON, VIA, 0, 7, 0,  1, 0, 1));
    tbl.push_back(v(0, NON, VIA, 0, 7, 1,  0, 0, 0));  // 19 final tick
    tbl.push_back(v(0, NON, VIA, 0, 7, 0,  0, 0, 0));
    tbl.push_back(v(1, IWM, IWM, 0, 0, 0,  1, 0, 0));  // 21 zero timeout
    tbl.push_back(v(1, IWM, IWM, 0, 0, 0,  1, 0, 0));
    tbl.push_back(v(0, NON, IWM, 0, 0, 0,  0, 0, 0));
    tbl.push_back(v(0, NON, IWM, 0, 0, 0,  0, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 1, 2, 0,  1, 1, 0));  // 25 clock gate
    tbl.push_back(v(0, NON, VIA, 1, 2, 0,  1, 1, 2));
    tbl.push_back(v(0, NON, VIA, 0, 2, 0,  1, 0, 2));
    tbl.push_back(v(0, NON, VIA, 0, 2, 1,  1, 0, 1));
    tbl.push_back(v(0, NON, VIA, 1, 2, 0,  1, 1, 1));
    tbl.push_back(v(0, NON, VIA, 1, 2, 1,  0, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 2, 0,  1, 0, 0));  // 31 back-to-back
    tbl.push_back(v(0, NON, VIA, 0, 2, 0,  1, 0, 2));
    tbl.push_back(v(1, VIA, VIA, 0, 2, 0,  1, 0, 2));
    tbl.push_back(v(0, NON, VIA, 0, 2, 0,  1, 0, 2));
    tbl.push_back(v(0, NON, VIA, 0, 2, 1,  1, 0, 1));
    tbl.push_back(v(0, NON, VIA, 0, 2, 1,  0, 0, 0));
    tbl.push_back(v(1, VIA, VIA, 0, 2, 0,  1, 0, 0));  // 37 non-hit in HOLD
    tbl.push_back(v(0, NON, VIA, 0, 2, 0,  1, 0, 2));
    tbl.push_back(v(1, SCC, VIA, 0, 2, 1,  1, 0, 1));
    tbl.push_back(v(1, SCC, VIA, 0, 2, 0,  1, 0, 1));
    tbl.push_back(v(0, NON, VIA, 0, 2, 1,  0, 0, 0));
    tbl.push_back(v(1, SND, SND, 0, 2, 0,  1, 0, 0));  // 42 retrigger
    tbl.push_back(v(0, NON, SND, 0, 2, 0,  1, 0, 2));
    tbl.push_back(v(1, SND, SND, 0, 5, 1,  1, 0, 2));  // 44 hit beats tick
    tbl.push_back(v(1, SND, SND, 0, 5, 1,  1, 0, 2));
    tbl.push_back(v(0, NON, SND, 0, 5, 0,  1, 0, 5));
    tbl.push_back(v(0, NON, SND, 0, 5, 1,  1, 0, 4));  // 47 HOLD, count 4

    #1 POR = 1'b1;
    #2;
    chk_all(-1, 0, 0, 0);
    step();
    step();
    chk_all(-2, 0, 0, 0);
    @(negedge CLK);
    POR = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      BACT = tbl[i].bact;
      sel = tbl[i].sel;
      en = tbl[i].en;
      SlowClockGate = tbl[i].cg;
      SlowTimeout = tbl[i].to;
      TimerTick = tbl[i].tick;
      step();
      chk_all(i, tbl[i].e_slow, tbl[i].e_cg, tbl[i].e_cnt);
    end

    // Reset mid-hold (count 4) while a Snd cycle begins.
    TimerTick = 1'b0;
    BACT = 1'b1;
    sel = SND;
    #2 POR = 1'b1;
    #1;
    chk_all(100, 0, 0, 0);
    step();
    chk_all(101, 0, 0, 0);
    POR = 1'b0;
    step();
    chk_all(102, 0, 0, 0);
    step();
    chk_all(103, 0, 0, 0);
    BACT = 1'b0;
    sel = NON;
    step();
    chk_all(104, 0, 0, 0);
    BACT = 1'b1;
    sel = SND;
    step();
    chk_all(105, 1, 0, 0);
    BACT = 1'b0;
    sel = NON;
    step();
    chk_all(106, 1, 0, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
